// File: rtl/lcd_select_ctrl_pkg.sv
// Shared constants and helpers for the LCD debug display select path.
// The display mux decodes the same one-hot select values.
package lcd_select_ctrl_pkg;

  localparam int NSRC = 5;

  localparam logic [4:0] SLCT_RSLT   = 5'b00001;
  localparam logic [4:0] SLCT_RDATA1 = 5'b00010;
  localparam logic [4:0] SLCT_RDATA2 = 5'b00100;
  localparam logic [4:0] SLCT_WDATA  = 5'b01000;
  localparam logic [4:0] SLCT_NEXTPC = 5'b10000;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  function automatic logic [4:0] slct_rotate(
    input logic [4:0] s
  );
    return {s[3:0], s[4]};
  endfunction

  function automatic logic slct_legal(
    input logic [4:0] s
  );
    return (s != 5'b0) &&
           ((s & (s - 5'd1)) == 5'b0);
  endfunction

  function automatic logic [2:0] idx_next(
    input logic [2:0] i
  );
    return (i == 3'(NSRC - 1)) ? 3'd0
                               : i + 3'd1;
  endfunction

endpackage

// File: rtl/lcd_select_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability filter,
// and a single-cycle press pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with LEVEL
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      LEVEL <= 1'b0;
      PRESS <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      PRESS <= 1'b0;
      if (sync2 == LEVEL) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        LEVEL <= sync2;
        PRESS <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_select_ctrl.sv
// LCD debug display source sequencer: manual stepping, timed
// auto rotation and freeze, driving a one-hot mux select.
module lcd_select_ctrl #(
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_NEXT,
  input  logic       BTN_MODE,
  input  logic       FREEZE,
  output logic [4:0] SLCT,
  output logic       AUTO,
  output logic [2:0] IDX
);

  import lcd_select_ctrl_pkg::*;

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST =
    DW'(DWELL_CYCLES - 1);

  logic          next_press;
  logic          mode_press;
  state_t        state;
  logic [DW-1:0] dwell;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN_NEXT),
    .LEVEL(),
    .PRESS(next_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN_MODE),
    .LEVEL(),
    .PRESS(mode_press)
  );

  assign AUTO = (state == ST_AUTO);

  // mode toggle outranks freeze and any pending step
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_MANUAL;
      SLCT  <= SLCT_RSLT;
      IDX   <= '0;
      dwell <= '0;
    end else if (!slct_legal(SLCT)) begin
      SLCT <= SLCT_RSLT;
      IDX  <= '0;
    end else if (mode_press) begin
      state <= (state == ST_AUTO) ? ST_MANUAL
                                  : ST_AUTO;
      dwell <= '0;
    end else if (!FREEZE) begin
      unique case (state)
        ST_MANUAL: begin
          if (next_press) begin
            SLCT <= slct_rotate(SLCT);
            IDX  <= idx_next(IDX);
          end
        end
        ST_AUTO: begin
          if (next_press ||
              dwell == DWELL_LAST) begin
            SLCT  <= slct_rotate(SLCT);
            IDX   <= idx_next(IDX);
            dwell <= '0;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
